// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    // Parity-mode encodings (value of the PARITY_ODD parameter).
    localparam bit PAR_MODE_EVEN = 1'b0;
    localparam bit PAR_MODE_ODD  = 1'b1;

    // Width of the bit timer: it must hold values up to CLKS_PER_BIT-1.
    function automatic int timer_width(input int clks_per_bit);
        if (clks_per_bit <= 2)
            return 1;
        return $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Loadable down-counter producing the mid-bit sample strobe. After a load
// the strobe fires when the count reaches zero, then every CLKS_PER_BIT
// cycles while run_i stays high.
module rx_bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int TW           = timer_width(CLKS_PER_BIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          run_i,
    output logic          strobe_o
);

    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign strobe_o = run_i && (cnt_q == '0);

    // Next count: load wins, otherwise count down and wrap to one bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (run_i)
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/parity/stop decoding with a one-deep
// VALID/READY output buffer and sticky error flags.
module serial_frame_rx
    import serial_pkg::*;
#(
    parameter int W            = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b1,
    parameter bit PARITY_ODD   = PAR_MODE_EVEN
) (
    input  logic         clk,
    input  logic         CR,
    input  logic         SIN,
    input  logic         READY,
    input  logic         CLR_ERR,
    output logic [W-1:0] DATA,
    output logic         VALID,
    output logic         BUSY,
    output logic         FRAME_ERR,
    output logic         PAR_ERR,
    output logic         OVERRUN
);

    localparam int TW   = timer_width(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = (W <= 1) ? 1 : $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);
    // With a one-cycle bit the start sample is the detecting edge itself,
    // so the first data bit is due one full period later.
    localparam logic [TW-1:0] START_LOAD = (HALF == 0) ? TW'(CLKS_PER_BIT - 1)
                                                       : TW'(HALF - 1);

    rx_state_e state_q;
    rx_state_e state_d;

    logic strobe;
    logic tmr_load;
    logic tmr_run;
    logic samp_data;
    logic samp_par;
    logic samp_stop;

    logic [W-1:0]  shift_q,   shift_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          mism_q,    mism_d;
    logic [W-1:0]  data_q,    data_d;
    logic          valid_q,   valid_d;
    logic          ferr_q,    ferr_d;
    logic          perr_q,    perr_d;
    logic          ovr_q,     ovr_d;

    logic deliver;
    logic ferr_set;
    logic perr_set;
    logic ovr_set;

    rx_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .TW           (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (CR),
        .load_i     (tmr_load),
        .load_val_i (START_LOAD),
        .run_i      (tmr_run),
        .strobe_o   (strobe)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge CR) begin
        if (CR)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!SIN) state_d = (HALF == 0) ? ST_DATA : ST_START;
            ST_START:  if (strobe) state_d = SIN ? ST_IDLE : ST_DATA;
            ST_DATA:   if (strobe && (bit_cnt_q == LAST_BIT))
                           state_d = PARITY_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (strobe) state_d = ST_STOP;
            ST_STOP:   if (strobe) state_d = SIN ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (SIN) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: timer control and per-state sample enables.
    always_comb begin
        BUSY      = (state_q != ST_IDLE);
        tmr_load  = (state_q == ST_IDLE) && !SIN;
        tmr_run   = (state_q != ST_IDLE) && (state_q != ST_BREAK);
        samp_data = (state_q == ST_DATA)   && strobe;
        samp_par  = (state_q == ST_PARITY) && strobe;
        samp_stop = (state_q == ST_STOP)   && strobe;
    end

    // Stop-sample outcome: a low stop bit outranks a parity mismatch.
    assign ferr_set = samp_stop && !SIN;
    assign perr_set = samp_stop &&  SIN &&  mism_q;
    assign deliver  = samp_stop &&  SIN && !mism_q;
    assign ovr_set  = deliver && valid_q && !READY;

    // Datapath next-state: shifter, bit count, parity check, buffer, flags.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        mism_d    = mism_q;
        data_d    = data_q;
        valid_d   = valid_q;

        if (state_q == ST_IDLE) begin
            bit_cnt_d = '0;
            mism_d    = 1'b0;
        end

        if (samp_data) begin
            shift_d        = shift_q >> 1;
            shift_d[W-1]   = SIN;
            bit_cnt_d      = bit_cnt_q + 1'b1;
        end

        if (samp_par)
            mism_d = (((^shift_q) ^ SIN) != PARITY_ODD);

        if (deliver && (!valid_q || READY)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (valid_q && READY) begin
            valid_d = 1'b0;
        end

        ferr_d = ferr_set || (ferr_q && !CLR_ERR);
        perr_d = perr_set || (perr_q && !CLR_ERR);
        ovr_d  = ovr_set  || (ovr_q  && !CLR_ERR);
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge CR) begin
        if (CR) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            mism_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            mism_q    <= mism_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign DATA      = data_q;
    assign VALID     = valid_q;
    assign FRAME_ERR = ferr_q;
    assign PAR_ERR   = perr_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx (W=4, 4 clocks/bit, even parity).
module tb_serial_frame_rx;

    localparam int C    = 4;
    localparam int HALF = C / 2;

    logic       clk = 1'b0;
    logic       CR;
    logic       SIN;
    logic       READY;
    logic       CLR_ERR;
    logic [3:0] DATA;
    logic       VALID;
    logic       BUSY;
    logic       FRAME_ERR;
    logic       PAR_ERR;
    logic       OVERRUN;

    int errors = 0;
    int checks = 0;
    logic [3:0] sb[$];
    int   ferr_rises = 0;
    logic ferr_prev  = 1'b0;

    serial_frame_rx #(
        .W            (4),
        .CLKS_PER_BIT (C),
        .PARITY_EN    (1'b1),
        .PARITY_ODD   (1'b0)
    ) dut (
        .clk       (clk),
        .CR        (CR),
        .SIN       (SIN),
        .READY     (READY),
        .CLR_ERR   (CLR_ERR),
        .DATA      (DATA),
        .VALID     (VALID),
        .BUSY      (BUSY),
        .FRAME_ERR (FRAME_ERR),
        .PAR_ERR   (PAR_ERR),
        .OVERRUN   (OVERRUN)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each accepted handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!CR && VALID && READY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no word", DATA);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                $display("rx word %b (expected %b)", DATA, e);
                chk("sb_data", {28'd0, DATA}, {28'd0, e});
            end
        end
        if (FRAME_ERR && !ferr_prev)
            ferr_rises++;
        ferr_prev = FRAME_ERR;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_clr();
        CLR_ERR = 1'b1;
        step();
        CLR_ERR = 1'b0;
    endtask

    task automatic drain();
        READY = 1'b1;
        step();
        READY = 1'b0;
    endtask

    // Send one frame; optionally raise READY only across the stop-sample edge
    // and optionally check VALID latency around that edge.
    task automatic send_frame(input logic [3:0] w, input bit bad_par, input bit bad_stop,
                              input bit rdy_stop, input bit chk_lat);
        bit full;
        bit bits [7];
        full    = (sb.size() != 0);
        bits[0] = 1'b0;
        for (int i = 0; i < 4; i++) bits[i+1] = w[i];
        bits[5] = (^w) ^ bad_par;
        bits[6] = !bad_stop;
        $display("tx frame %b bad_par=%0d bad_stop=%0d ready_at_stop=%0d", w, bad_par, bad_stop, rdy_stop);
        for (int k = 0; k < 7; k++) begin
            SIN = bits[k];
            for (int c = 0; c < C; c++) begin
                if (k == 6 && c == HALF) begin
                    if (rdy_stop) READY = 1'b1;
                    if (chk_lat) chk("latency_pre", {31'd0, VALID}, 32'd0);
                end
                if (k == 6 && c == HALF + 1) begin
                    if (rdy_stop) READY = 1'b0;
                    if (chk_lat) chk("latency_post", {31'd0, VALID}, 32'd1);
                end
                step();
            end
        end
        if (!bad_par && !bad_stop && (!full || rdy_stop))
            sb.push_back(w);
    endtask

    typedef struct {
        logic [3:0] word;
        bit         bad_par;
        bit         exp_valid;
        bit         exp_perr;
    } vec_t;

    vec_t tbl [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low_cnt;
        tbl[0] = '{4'b1000, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{4'b0001, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{4'b1111, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'b0110, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{4'b0111, 1'b1, 1'b0, 1'b1};

        CR = 1'b1; SIN = 1'b1; READY = 1'b0; CLR_ERR = 1'b0;
        repeat (3) step();
        chk("rst_data",  {28'd0, DATA},     32'd0);
        chk("rst_valid", {31'd0, VALID},    32'd0);
        chk("rst_busy",  {31'd0, BUSY},     32'd0);
        chk("rst_ferr",  {31'd0, FRAME_ERR}, 32'd0);
        chk("rst_perr",  {31'd0, PAR_ERR},  32'd0);
        chk("rst_ovr",   {31'd0, OVERRUN},  32'd0);
        CR = 1'b0;
        step();

        // Table-driven single frames with READY low.
        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i].word, tbl[i].bad_par, 1'b0, 1'b0, i == 0);
            step();
            chk("tbl_valid", {31'd0, VALID},     {31'd0, tbl[i].exp_valid});
            chk("tbl_perr",  {31'd0, PAR_ERR},   {31'd0, tbl[i].exp_perr});
            chk("tbl_ferr",  {31'd0, FRAME_ERR}, 32'd0);
            chk("tbl_ovr",   {31'd0, OVERRUN},   32'd0);
            drain();
            chk("tbl_drained", {31'd0, VALID}, 32'd0);
            pulse_clr();
            chk("tbl_perr_clr", {31'd0, PAR_ERR}, 32'd0);
        end

        // False start: one low cycle only.
        SIN = 1'b0; step();
        chk("fs_busy_start", {31'd0, BUSY}, 32'd1);
        SIN = 1'b1; step(); step();
        chk("fs_busy_idle", {31'd0, BUSY}, 32'd0);
        repeat (4) step();
        chk("fs_valid", {31'd0, VALID}, 32'd0);
        chk("fs_flags", {29'd0, FRAME_ERR, PAR_ERR, OVERRUN}, 32'd0);

        // Frame error followed by a held-low break.
        ferr_rises = 0;
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (!BUSY) low_cnt++;
            step();
        end
        chk("brk_busy_low_cycles", low_cnt, 0);
        chk("brk_ferr", {31'd0, FRAME_ERR}, 32'd1);
        chk("brk_ferr_once", ferr_rises, 1);
        chk("brk_perr", {31'd0, PAR_ERR}, 32'd0);
        SIN = 1'b1; step(); step();
        chk("brk_idle", {31'd0, BUSY}, 32'd0);
        send_frame(4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("brk_next_valid", {31'd0, VALID}, 32'd1);
        drain();
        pulse_clr();
        chk("brk_ferr_clr", {31'd0, FRAME_ERR}, 32'd0);

        // Overrun: back-to-back frames, buffer never read.
        send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("ovr_valid", {31'd0, VALID},   32'd1);
        chk("ovr_flag",  {31'd0, OVERRUN}, 32'd1);
        chk("ovr_data",  {28'd0, DATA},    32'h0000_000A);
        drain();
        pulse_clr();
        chk("ovr_clr", {31'd0, OVERRUN}, 32'd0);

        // Same pair, READY on the second stop edge: replace without overrun.
        send_frame(4'b1010, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        chk("rpl_valid", {31'd0, VALID},   32'd1);
        chk("rpl_ovr",   {31'd0, OVERRUN}, 32'd0);
        chk("rpl_data",  {28'd0, DATA},    32'h0000_0006);
        drain();

        // Mid-frame reset with a buffered word and a sticky flag present.
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
        SIN = 1'b0; repeat (C) step();
        SIN = 1'b1; repeat (2) step();
        chk("mrst_pre_busy", {31'd0, BUSY},    32'd1);
        chk("mrst_pre_perr", {31'd0, PAR_ERR}, 32'd1);
        #1 CR = 1'b1;
        #1;
        chk("mrst_data",  {28'd0, DATA},  32'd0);
        chk("mrst_valid", {31'd0, VALID}, 32'd0);
        chk("mrst_busy",  {31'd0, BUSY},  32'd0);
        chk("mrst_flags", {29'd0, FRAME_ERR, PAR_ERR, OVERRUN}, 32'd0);
        sb.delete();
        step();
        CR = 1'b0;
        step();
        send_frame(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        chk("mrst_next_valid", {31'd0, VALID}, 32'd1);
        chk("mrst_next_data",  {28'd0, DATA},  32'h0000_000F);
        drain();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
